register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, 2..64; AW = log2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 means write-to-read forwarding in the same cycle; 0 means none.
REQ-005 SHALL have parameter ZERO_REG, default 1: 1 means register 0 is hardwired to zero.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port clearReq, input, 1 bit: request to re-zero the whole bank.
REQ-009 SHALL have port RegWrite, input, 1 bit: write enable.
REQ-010 SHALL have port writeReg, input, AW bits: write address.
REQ-011 SHALL have port writeData, input, XLEN bits: write data.
REQ-012 SHALL have port readReg, input, NREAD*AW bits: packed read addresses; port i is at [i*AW +: AW].
REQ-013 SHALL have port readData, output, NREAD*XLEN bits: packed read data; port i is at [i*XLEN +: XLEN].
REQ-014 SHALL have port ready, output, 1 bit: high when the bank accepts writes and returns valid reads.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR, a counter clrIdx SHALL write zero to register clrIdx each cycle, from 0 to NREGS-1, then move to READY; the sequence takes exactly NREGS cycles.
REQ-017 In CLEAR: ready=0, all readData=0, RegWrite ignored.
REQ-018 clearReq sampled high in READY SHALL enter CLEAR with clrIdx=0 on the next edge; any RegWrite in that same cycle is dropped.
REQ-019 clearReq asserted during CLEAR SHALL be ignored, with no restart.
REQ-020 In READY, RegWrite=1 SHALL write writeData to registers[writeReg] at the rising edge.
REQ-021 If ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0.
REQ-022 Reads SHALL be combinational with zero-cycle latency: readData_i = registers[readReg_i].
REQ-023 If BYPASS=1, ready=1, RegWrite=1, readReg_i==writeReg and the address is not a hardwired zero, readData_i SHALL equal writeData in the same cycle.
REQ-024 If BYPASS=0, a read SHALL return the old value until the edge after the write.
REQ-025 Multiple read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-026 There SHALL be no width conversion: writeData is stored as-is, with no sign or zero extension.

Reset
REQ-027 reset=1 at a rising edge SHALL set state=CLEAR, clrIdx=0 and ready=0; it overrides clearReq and RegWrite.
REQ-028 reset asserted mid-CLEAR SHALL restart at clrIdx=0; a full NREGS-cycle clear follows reset deassertion.
REQ-029 Register contents SHALL be zeroed only by the CLEAR sequence, not by reset directly, so the storage can map to RAM.
REQ-030 Outputs after reset SHALL be ready=0 and readData=0 until CLEAR completes.

Structure
REQ-031 A shared package register_bank_pkg SHALL hold the state enum (CLEAR, READY) and the default parameter constants (XLEN, NREGS, NREAD).
REQ-032 AW SHALL be derived locally with $clog2(NREGS).
REQ-033 Sub-module register_bank_rdport SHALL be instantiated NREAD times by generate; it holds one read mux plus the bypass and zero-register logic.
REQ-034 Storage SHALL be a single array of NREGS x XLEN with one write port.

Verification
REQ-035 Reset, defaults: pulse reset for 1 cycle -> ready=0 for exactly 32 cycles, then 1; read of any address returns 0x00000000.
REQ-036 Write/read: write 0xDEADBEEF to reg 5, then read reg 5 on port 0 and port 1 next cycle -> both return 0xDEADBEEF.
REQ-037 Zero register: write 0x12345678 to reg 0 -> readData for reg 0 is 0 in the same and following cycles.
REQ-038 Bypass: BYPASS=1, reg 7 holds 0x1, write 0xA5A5A5A5 to reg 7 while reading reg 7 -> same-cycle readData=0xA5A5A5A5; with BYPASS=0, same-cycle readData=0x1 and next cycle 0xA5A5A5A5.
REQ-039 clearReq with write: fill reg 3=0x33, assert clearReq and write reg 4=0x44 in the same cycle -> ready=0 for 32 cycles, then reg 3=0 and reg 4=0.
REQ-040 Reset mid-clear, NREGS=16: assert reset at clear cycle 10 -> ready rises exactly 16 cycles after reset deassertion; writes during CLEAR are not visible afterwards.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared types and default sizing for the register bank.
package register_bank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } bankState_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NREAD = 2;

endpackage

// File: rtl/register_bank_rdport.sv
// One combinational read port: storage mux, write forwarding and hardwired-zero handling.
module register_bank_rdport
    import register_bank_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            ready,
    input  logic [AW-1:0]   rdAddr,
    input  logic [XLEN-1:0] regs [NREGS],
    input  logic            RegWrite,
    input  logic [AW-1:0]   writeReg,
    input  logic [XLEN-1:0] writeData,
    output logic [XLEN-1:0] rdData
);

    logic isZeroAddr;
    logic forward;

    assign isZeroAddr = (ZERO_REG != 0) && (rdAddr == '0);
    assign forward    = (BYPASS != 0) && RegWrite && (rdAddr == writeReg);

    always_comb begin
        rdData = '0;
        if (ready && !isZeroAddr) begin
            if (forward) begin
                rdData = writeData;
            end else begin
                rdData = regs[rdAddr];
            end
        end
    end

endmodule

// File: rtl/register_bank.sv
// Multi-port register bank that zeroes its storage with a sequential clear pass
// after reset or on request, so the array carries no reset and can map to RAM.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   CLEAR | writing zero to regs[clrIdx], 0..NREGS-1; reads 0, writes ignored
//   READY | normal operation; clearReq restarts the clear pass
module register_bank
    import register_bank_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NREAD    = DEF_NREAD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clearReq,
    input  logic                  RegWrite,
    input  logic [AW-1:0]         writeReg,
    input  logic [XLEN-1:0]       writeData,
    input  logic [NREAD*AW-1:0]   readReg,
    output logic [NREAD*XLEN-1:0] readData,
    output logic                  ready
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];
    bankState_t      state;
    logic [AW-1:0]   clrIdx;

    logic            wrEn;
    logic [AW-1:0]   wrAddr;
    logic [XLEN-1:0] wrData;
    logic            userWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            clrIdx <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clrIdx == LAST_IDX) begin
                        state  <= READY;
                        ready  <= 1'b1;
                        clrIdx <= '0;
                    end else begin
                        clrIdx <= clrIdx + 1'b1;
                    end
                end
                READY: begin
                    if (clearReq) begin
                        state  <= CLEAR;
                        ready  <= 1'b0;
                        clrIdx <= '0;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    ready  <= 1'b0;
                    clrIdx <= '0;
                end
            endcase
        end
    end

    // Single write port shared by the clear pass and user writes; a write
    // coinciding with clearReq is dropped.
    assign userWrite = (state == READY) && RegWrite && !clearReq
                       && !((ZERO_REG != 0) && (writeReg == '0));

    always_comb begin
        wrEn   = 1'b0;
        wrAddr = writeReg;
        wrData = writeData;
        if (!reset) begin
            if (state == CLEAR) begin
                wrEn   = 1'b1;
                wrAddr = clrIdx;
                wrData = '0;
            end else if (userWrite) begin
                wrEn = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            regs[wrAddr] <= wrData;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : gRead
        register_bank_rdport #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) uPort (
            .ready     (ready),
            .rdAddr    (readReg[i*AW +: AW]),
            .regs      (regs),
            .RegWrite  (RegWrite),
            .writeReg  (writeReg),
            .writeData (writeData),
            .rdData    (readData[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench: default bank, a no-bypass bank and a 16-entry bank.
module tb_register_bank;

    logic        clk;
    logic        reset;
    logic        clearReq;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [9:0]  readReg;
    logic [63:0] readDataA;
    logic [63:0] readDataB;
    logic        readyA;
    logic        readyB;

    logic        resetC;
    logic        RegWriteC;
    logic [3:0]  writeRegC;
    logic [31:0] writeDataC;
    logic [7:0]  readRegC;
    logic [63:0] readDataC;
    logic        readyC;

    int tests = 0;
    int fails = 0;

    register_bank dutA (
        .clk(clk), .reset(reset), .clearReq(clearReq), .RegWrite(RegWrite),
        .writeReg(writeReg), .writeData(writeData), .readReg(readReg),
        .readData(readDataA), .ready(readyA)
    );

    register_bank #(.BYPASS(0)) dutB (
        .clk(clk), .reset(reset), .clearReq(clearReq), .RegWrite(RegWrite),
        .writeReg(writeReg), .writeData(writeData), .readReg(readReg),
        .readData(readDataB), .ready(readyB)
    );

    register_bank #(.NREGS(16)) dutC (
        .clk(clk), .reset(resetC), .clearReq(1'b0), .RegWrite(RegWriteC),
        .writeReg(writeRegC), .writeData(writeDataC), .readReg(readRegC),
        .readData(readDataC), .ready(readyC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int cntA;
        int cntB;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        readReg = {5'd31, 5'd1};
        #1;
        tests++;
        if (readyA !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_low got %b want 0", readyA);
        end
        tests++;
        if (readDataA !== 64'h0) begin
            fails++;
            $display("FAIL reset_readdata_zero got %h want 0", readDataA);
        end
        cntA = 0;
        cntB = 0;
        while (!readyA && cntA < 100) begin
            @(negedge clk);
            cntA++;
            if (!readyB) cntB = cntA;
        end
        cntB++;
        tests++;
        if (cntA !== 32) begin
            fails++;
            $display("FAIL reset_clear_len_A got %0d want 32", cntA);
        end
        tests++;
        if (cntB !== 32) begin
            fails++;
            $display("FAIL reset_clear_len_B got %0d want 32", cntB);
        end
        #1;
        tests++;
        if (readDataA !== 64'h0) begin
            fails++;
            $display("FAIL reset_reads_zero got %h want 0", readDataA);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        RegWrite  = 1'b1;
        writeReg  = 5'd5;
        writeData = 32'hDEADBEEF;
        readReg   = {5'd0, 5'd0};
        @(negedge clk);
        RegWrite = 1'b0;
        readReg  = {5'd5, 5'd5};
        #1;
        tests++;
        if (readDataA !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL write_read_A got %h want deadbeefdeadbeef", readDataA);
        end
        tests++;
        if (readDataB !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL write_read_B got %h want deadbeefdeadbeef", readDataB);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        RegWrite  = 1'b1;
        writeReg  = 5'd0;
        writeData = 32'h12345678;
        readReg   = {5'd0, 5'd0};
        #1;
        tests++;
        if (readDataA !== 64'h0) begin
            fails++;
            $display("FAIL zero_reg_same got %h want 0", readDataA);
        end
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        tests++;
        if (readDataA !== 64'h0 || readDataB !== 64'h0) begin
            fails++;
            $display("FAIL zero_reg_next got %h/%h want 0", readDataA, readDataB);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        RegWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'h1;
        @(negedge clk);
        writeData = 32'hA5A5A5A5;
        readReg   = {5'd7, 5'd7};
        #1;
        tests++;
        if (readDataA !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            fails++;
            $display("FAIL bypass_on_same got %h want a5a5a5a5a5a5a5a5", readDataA);
        end
        tests++;
        if (readDataB !== {32'h1, 32'h1}) begin
            fails++;
            $display("FAIL bypass_off_same got %h want 0000000100000001", readDataB);
        end
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        tests++;
        if (readDataB !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            fails++;
            $display("FAIL bypass_off_next got %h want a5a5a5a5a5a5a5a5", readDataB);
        end
        readReg = {5'd5, 5'd7};
        #1;
        tests++;
        if (readDataA !== {32'hDEADBEEF, 32'hA5A5A5A5}) begin
            fails++;
            $display("FAIL independent_ports got %h want deadbeefa5a5a5a5", readDataA);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h80000000;
        vals[1] = 32'hFFFFFFFF;
        vals[2] = 32'h0000007F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            RegWrite  = 1'b1;
            writeReg  = 5'(10 + i);
            writeData = vals[i];
        end
        @(negedge clk);
        RegWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            readReg = {5'(10 + i), 5'(10 + i)};
            #1;
            tests++;
            if (readDataB[31:0] !== vals[i] || readDataB[63:32] !== vals[i]) begin
                fails++;
                $display("FAIL back_to_back reg%0d got %h want %h", 10 + i, readDataB, vals[i]);
            end
        end
    endtask

    task automatic test_clear_with_write();
        int cnt;
        @(negedge clk);
        RegWrite  = 1'b1;
        writeReg  = 5'd3;
        writeData = 32'h33;
        @(negedge clk);
        clearReq  = 1'b1;
        writeReg  = 5'd4;
        writeData = 32'h44;
        @(negedge clk);
        clearReq = 1'b0;
        RegWrite = 1'b1;
        writeReg = 5'd5;
        readReg  = {5'd5, 5'd3};
        #1;
        tests++;
        if (readyA !== 1'b0 || readDataA !== 64'h0) begin
            fails++;
            $display("FAIL clear_outputs got ready=%b data=%h want 0/0", readyA, readDataA);
        end
        cnt = 0;
        while (!readyA && cnt < 100) begin
            @(negedge clk);
            cnt++;
            clearReq = (cnt == 10);
        end
        clearReq = 1'b0;
        RegWrite = 1'b0;
        tests++;
        if (cnt !== 32) begin
            fails++;
            $display("FAIL clear_len got %0d want 32", cnt);
        end
        readReg = {5'd4, 5'd3};
        #1;
        tests++;
        if (readDataA !== 64'h0 || readDataB !== 64'h0) begin
            fails++;
            $display("FAIL clear_contents got %h/%h want 0", readDataA, readDataB);
        end
        readReg = {5'd5, 5'd5};
        #1;
        tests++;
        if (readDataA !== 64'h0) begin
            fails++;
            $display("FAIL clear_drops_writes got %h want 0", readDataA);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        @(negedge clk);
        resetC = 1'b1;
        @(negedge clk);
        resetC = 1'b0;
        cnt = 0;
        while (!readyC && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        RegWriteC  = 1'b1;
        writeRegC  = 4'd9;
        writeDataC = 32'h99;
        @(negedge clk);
        writeRegC  = 4'd2;
        writeDataC = 32'hCAFE;
        @(negedge clk);
        RegWriteC = 1'b0;
        readRegC  = {4'd2, 4'd9};
        #1;
        tests++;
        if (readDataC !== {32'hCAFE, 32'h99}) begin
            fails++;
            $display("FAIL small_bank_rw got %h want 0000cafe00000099", readDataC);
        end
        @(negedge clk);
        resetC = 1'b1;
        @(negedge clk);
        resetC = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        resetC = 1'b1;
        @(negedge clk);
        resetC     = 1'b0;
        RegWriteC  = 1'b1;
        writeRegC  = 4'd9;
        writeDataC = 32'h77;
        cnt = 0;
        while (!readyC && cnt < 100) begin
            @(negedge clk);
            cnt++;
            writeRegC = (cnt[0]) ? 4'd9 : 4'd3;
        end
        RegWriteC = 1'b0;
        tests++;
        if (cnt !== 16) begin
            fails++;
            $display("FAIL mid_clear_len got %0d want 16", cnt);
        end
        readRegC = {4'd3, 4'd9};
        #1;
        tests++;
        if (readDataC !== 64'h0) begin
            fails++;
            $display("FAIL mid_clear_writes got %h want 0", readDataC);
        end
        readRegC = {4'd2, 4'd2};
        #1;
        tests++;
        if (readDataC !== 64'h0) begin
            fails++;
            $display("FAIL mid_clear_contents got %h want 0", readDataC);
        end
    endtask

    initial begin
        reset      = 1'b1;
        clearReq   = 1'b0;
        RegWrite   = 1'b0;
        writeReg   = '0;
        writeData  = '0;
        readReg    = '0;
        resetC     = 1'b1;
        RegWriteC  = 1'b0;
        writeRegC  = '0;
        writeDataC = '0;
        readRegC   = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        resetC = 1'b0;

        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_clear_with_write();
        test_reset_mid_clear();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
